// File: rtl/unsat_clause_random_scanner.sv
// rtl/unsat_clause_random_scanner.sv - circular scanner returning the first unsatisfied clause
//
// Snapshots the clause-satisfied flags on an accepted start and walks them one
// clause per cycle. The walk begins at index 0 or at an offset taken from a
// free-running LFSR. It stops at the first unsatisfied clause, or after every
// clause has been examined once.
//
// Ports:
//   in_clk               clock, rising edge
//   in_reset_n           asynchronous active-low reset
//   in_start             search request, honoured only while idle
//   in_clauses_satisfied bit i = clause i satisfied, captured on accept
//   in_random_mode       0: start at index 0, 1: start at LFSR offset
//   out_busy             scan in progress
//   out_done             one-cycle result-valid pulse
//   out_clause_index     index of the unsatisfied clause found
//   out_all_satisfied    last search found no unsatisfied clause
module unsat_clause_random_scanner #(
  parameter int                  NUM_CLAUSES                        = 8,
  parameter int                  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
  parameter int                  LFSR_WIDTH                         = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED                        = 16'hACE1
) (
  input  logic                                          in_clk,
  input  logic                                          in_reset_n,
  input  logic                                          in_start,
  input  logic [NUM_CLAUSES-1:0]                        in_clauses_satisfied,
  input  logic                                          in_random_mode,
  output logic                                          out_busy,
  output logic                                          out_done,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic                                          out_all_satisfied
);

  localparam int IW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SCAN = 1'b1;

  // x^16+x^14+x^13+x^11+1 for the 16-bit case. Other widths fall back to the
  // two top bits, which keeps the register non-stuck but not maximal length.
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS =
    (LFSR_WIDTH == 16) ? LFSR_WIDTH'(32'h0000_B400)
                       : (LFSR_WIDTH'(3) << (LFSR_WIDTH - 2));

  localparam logic [IW:0]   NC_EXT  = (IW + 1)'(NUM_CLAUSES);
  localparam logic [IW-1:0] NC_IDX  = IW'(NUM_CLAUSES);
  localparam logic [IW-1:0] LAST_IX = IW'(NUM_CLAUSES - 1);

  logic [0:0]             state;
  logic [LFSR_WIDTH-1:0]  lfsr;
  logic [NUM_CLAUSES-1:0] snapshot;
  logic [IW-1:0]          pointer;
  logic [IW-1:0]          counter;

  logic                   lfsr_fb;
  logic [IW-1:0]          raw_offset;
  logic [IW-1:0]          start_offset;

  assign lfsr_fb    = ^(lfsr & LFSR_TAPS);
  assign raw_offset = lfsr[IW-1:0];

  // The index width bounds raw below 2*NUM_CLAUSES, so one conditional
  // subtract folds it into range.
  always_comb begin
    start_offset = '0;
    if (in_random_mode) begin
      if ({1'b0, raw_offset} >= NC_EXT) begin
        start_offset = raw_offset - NC_IDX;
      end else begin
        start_offset = raw_offset;
      end
    end
  end

  // The LFSR runs in every state so the offset depends on when start arrives.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[LFSR_WIDTH-2:0], lfsr_fb};
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state             <= STATE_IDLE;
      snapshot          <= '0;
      pointer           <= '0;
      counter           <= '0;
      out_busy          <= 1'b0;
      out_done          <= 1'b0;
      out_clause_index  <= '0;
      out_all_satisfied <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (in_start) begin
            snapshot <= in_clauses_satisfied;
            pointer  <= start_offset;
            counter  <= '0;
            out_busy <= 1'b1;
            state    <= STATE_SCAN;
          end
        end
        STATE_SCAN: begin
          if (!snapshot[pointer]) begin
            out_clause_index  <= pointer;
            out_all_satisfied <= 1'b0;
            out_done          <= 1'b1;
            out_busy          <= 1'b0;
            state             <= STATE_IDLE;
          end else if (counter == LAST_IX) begin
            out_clause_index  <= '0;
            out_all_satisfied <= 1'b1;
            out_done          <= 1'b1;
            out_busy          <= 1'b0;
            state             <= STATE_IDLE;
          end else begin
            pointer <= (pointer == LAST_IX) ? '0 : pointer + 1'b1;
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state    <= STATE_IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
